// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// The optional bus-wait timeout is enabled with the LSU_TIMEOUT_EN macro.
package mem_stage_lsu_pkg;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_size_t;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_RESP,
      LSU_DONE
   } lsu_state_t;

   localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

   // Unknown size encodings are handled as word accesses everywhere.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offset);
      mem_size_t sz;
      sz = mem_size_t'(size);
      case (sz)
         MEM_B, MEM_BU: return 1'b0;
         MEM_H, MEM_HU: return offset[0];
         default:       return |offset;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store strobe/data replication and load
// byte/halfword extraction with sign or zero extension.
module lsu_lane_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   mem_size_t   sz;
   logic [31:0] shifted;

   assign sz      = mem_size_t'(size);
   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      wstrb     = 4'b1111;
      wdata     = store_data;
      load_data = shifted;
      case (sz)
         MEM_B: begin
            wstrb     = 4'b0001 << offset;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{shifted[7]}}, shifted[7:0]};
         end
         MEM_BU: begin
            wstrb     = 4'b0001 << offset;
            wdata     = {4{store_data[7:0]}};
            load_data = {24'd0, shifted[7:0]};
         end
         MEM_H: begin
            wstrb     = 4'b0011 << offset;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{shifted[15]}}, shifted[15:0]};
         end
         MEM_HU: begin
            wstrb     = 4'b0011 << offset;
            wdata     = {2{store_data[15:0]}};
            load_data = {16'd0, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: single-outstanding valid/ready bus access with pipeline stall.
// Define LSU_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES on the bus.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   input  logic [2:0]  mem_size_i,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_req_addr,
   output logic        bus_req_we,
   output logic [3:0]  bus_req_wstrb,
   output logic [31:0] bus_req_wdata,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_rdata,
   input  logic        bus_rsp_err,
   output logic        stall_o,
   output logic [31:0] load_data_o,
   output logic        done_o,
   output logic        misaligned_o,
   output logic        bus_err_o
);

   lsu_state_t  state_q, state_d;
   logic [31:0] addr_q;
   logic [2:0]  size_q;
   logic        we_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;
   logic [31:0] load_q;
   logic        err_q;

   logic        access;
   logic        in_idle;
   logic        capture;
   logic        rsp_take;
   logic        to_hit;
   logic        to_abort;
   logic [2:0]  al_size;
   logic [1:0]  al_offset;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_load;

   // Holding reset low masks the inputs so every output reads 0 at once.
   assign access  = reset & (mem_read_i | mem_write_i);
   assign in_idle = (state_q == LSU_IDLE);

   // One aligner serves both directions: live inputs while idle, captured fields afterwards.
   assign al_size   = in_idle ? mem_size_i  : size_q;
   assign al_offset = in_idle ? addr_i[1:0] : addr_q[1:0];

   lsu_lane_align u_align (
      .size       (al_size),
      .offset     (al_offset),
      .store_data (store_data_i),
      .rdata      (bus_rsp_rdata),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt_q;

   // Fires on the cycle the wait count reaches TIMEOUT_CYCLES.
   assign to_hit = ((32'(to_cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt_q <= '0;
      end else if (capture) begin
         to_cnt_q <= '0;
      end else if ((state_q == LSU_REQ) || (state_q == LSU_RESP)) begin
         to_cnt_q <= to_cnt_q + CNT_W'(1);
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      capture      = 1'b0;
      rsp_take     = 1'b0;
      to_abort     = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (access) begin
               if (is_misaligned(mem_size_i, addr_i[1:0])) begin
                  misaligned_o = 1'b1;
               end else begin
                  stall_o = 1'b1;
                  capture = 1'b1;
                  state_d = LSU_REQ;
               end
            end
         end
         LSU_REQ: begin
            stall_o = 1'b1;
            if (bus_req_ready) begin
               state_d = LSU_RESP;
            end else if (to_hit) begin
               to_abort = 1'b1;
               state_d  = LSU_DONE;
            end
         end
         LSU_RESP: begin
            stall_o = 1'b1;
            if (bus_rsp_valid) begin
               rsp_take = 1'b1;
               state_d  = LSU_DONE;
            end else if (to_hit) begin
               to_abort = 1'b1;
               state_d  = LSU_DONE;
            end
         end
         LSU_DONE: begin
            state_d = LSU_IDLE;
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LSU_IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         wstrb_q <= '0;
         wdata_q <= '0;
         load_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q  <= addr_i;
            size_q  <= mem_size_i;
            we_q    <= mem_write_i;
            wstrb_q <= al_wstrb;
            wdata_q <= al_wdata;
            load_q  <= '0;
            err_q   <= 1'b0;
         end
         if (rsp_take) begin
            load_q <= we_q ? 32'd0 : al_load;
            err_q  <= bus_rsp_err;
         end
         if (to_abort) begin
            load_q <= '0;
            err_q  <= 1'b1;
         end
      end
   end

   assign bus_req_valid = (state_q == LSU_REQ);
   assign bus_req_addr  = {addr_q[31:2], 2'b00};
   assign bus_req_we    = we_q;
   assign bus_req_wstrb = wstrb_q;
   assign bus_req_wdata = wdata_q;
   assign done_o        = (state_q == LSU_DONE);
   assign load_data_o   = load_q;
   assign bus_err_o     = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized
// accesses compared against an arithmetic reference model.
module tb_mem_stage_lsu;
   import mem_stage_lsu_pkg::*;

   localparam int unsigned TB_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_i, mem_write_i;
   logic [31:0] addr_i, store_data_i;
   logic [2:0]  mem_size_i;
   logic        bus_req_valid, bus_req_ready, bus_req_we;
   logic [31:0] bus_req_addr, bus_req_wdata;
   logic [3:0]  bus_req_wstrb;
   logic        bus_rsp_valid, bus_rsp_err;
   logic [31:0] bus_rsp_rdata;
   logic        stall_o, done_o, misaligned_o, bus_err_o;
   logic [31:0] load_data_o;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_read_i    (mem_read_i),
      .mem_write_i   (mem_write_i),
      .addr_i        (addr_i),
      .store_data_i  (store_data_i),
      .mem_size_i    (mem_size_i),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_req_addr  (bus_req_addr),
      .bus_req_we    (bus_req_we),
      .bus_req_wstrb (bus_req_wstrb),
      .bus_req_wdata (bus_req_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata),
      .bus_rsp_err   (bus_rsp_err),
      .stall_o       (stall_o),
      .load_data_o   (load_data_o),
      .done_o        (done_o),
      .misaligned_o  (misaligned_o),
      .bus_err_o     (bus_err_o)
   );

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Reference model: lane rules as plain arithmetic on byte positions.
   function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * a[1:0]);
      case (sz)
         3'b000:  return (v[7:0]  >= 8'd128)     ? 32'(v[7:0])  - 32'd256   : 32'(v[7:0]);
         3'b001:  return (v[15:0] >= 16'd32768)  ? 32'(v[15:0]) - 32'd65536 : 32'(v[15:0]);
         3'b100:  return 32'(v[7:0]);
         3'b101:  return 32'(v[15:0]);
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [2:0] sz, input logic [31:0] a);
      case (sz)
         3'b000:  return 4'(1 << a[1:0]);
         3'b001:  return 4'(3 << a[1:0]);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
      case (sz)
         3'b000:  return 32'(d[7:0])  * 32'h0101_0101;
         3'b001:  return 32'(d[15:0]) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic m_mis(input logic [2:0] sz, input logic [31:0] a);
      if (sz == 3'b000 || sz == 3'b100) return 1'b0;
      if (sz == 3'b001 || sz == 3'b101) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   task automatic drive_op(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] sz);
      mem_read_i   = rd;
      mem_write_i  = wr;
      addr_i       = a;
      store_data_i = d;
      mem_size_i   = sz;
   endtask

   // Full aligned access; bus ready after rdy_dly cycles, response after rsp_dly cycles.
   task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] sz, input int rdy_dly,
                         input int rsp_dly, input logic [31:0] rdata, input logic err);
      logic [31:0] exp_load;
      exp_load = wr ? 32'd0 : m_load(sz, a, rdata);
      @(negedge clk);
      drive_op(rd, wr, a, d, sz);
      #1;
      chk1({tag, ".idle_stall"}, stall_o, 1'b1);
      chk1({tag, ".idle_mis"}, misaligned_o, 1'b0);
      chk1({tag, ".idle_valid"}, bus_req_valid, 1'b0);
      @(negedge clk);
      for (int i = 0; i <= rdy_dly; i++) begin
         chk1({tag, ".req_valid"}, bus_req_valid, 1'b1);
         chk1({tag, ".req_stall"}, stall_o, 1'b1);
         chk32({tag, ".req_addr"}, bus_req_addr, {a[31:2], 2'b00});
         chk1({tag, ".req_we"}, bus_req_we, wr);
         if (wr) begin
            chk32({tag, ".req_wstrb"}, 32'(bus_req_wstrb), 32'(m_wstrb(sz, a)));
            chk32({tag, ".req_wdata"}, bus_req_wdata, m_wdata(sz, d));
         end
         // Stray responses while the request is pending must be ignored.
         bus_rsp_valid = 1'($urandom_range(0, 1));
         bus_rsp_rdata = $urandom;
         bus_rsp_err   = 1'b1;
         if (i == rdy_dly) begin
            bus_req_ready = 1'b1;
            bus_rsp_valid = 1'b1;
         end
         @(negedge clk);
      end
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      for (int i = 0; i <= rsp_dly; i++) begin
         chk1({tag, ".resp_valid"}, bus_req_valid, 1'b0);
         chk1({tag, ".resp_stall"}, stall_o, 1'b1);
         chk1({tag, ".resp_done"}, done_o, 1'b0);
         if (i == rsp_dly) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = rdata;
            bus_rsp_err   = err;
         end
         @(negedge clk);
      end
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      drive_op(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      #1;
      chk1({tag, ".done"}, done_o, 1'b1);
      chk1({tag, ".done_stall"}, stall_o, 1'b0);
      chk32({tag, ".load"}, load_data_o, exp_load);
      chk1({tag, ".err"}, bus_err_o, err);
      @(negedge clk);
      chk1({tag, ".done_once"}, done_o, 1'b0);
      chk1({tag, ".idle_after"}, bus_req_valid, 1'b0);
   endtask

   task automatic misaligned(input string tag, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [2:0] sz);
      @(negedge clk);
      drive_op(rd, wr, a, 32'hA5A5_5A5A, sz);
      #1;
      chk1({tag, ".mis"}, misaligned_o, 1'b1);
      chk1({tag, ".stall"}, stall_o, 1'b0);
      chk1({tag, ".valid"}, bus_req_valid, 1'b0);
      @(negedge clk);
      chk1({tag, ".valid2"}, bus_req_valid, 1'b0);
      chk1({tag, ".done"}, done_o, 1'b0);
      drive_op(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
   endtask

   initial begin
      logic        wr, rd;
      logic [2:0]  sz;
      logic [31:0] a;
      reset         = 1'b0;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = 32'd0;
      bus_rsp_err   = 1'b0;
      drive_op(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      repeat (2) @(negedge clk);
      chk1("rst.valid", bus_req_valid, 1'b0);
      chk1("rst.stall", stall_o, 1'b0);
      chk1("rst.done", done_o, 1'b0);
      chk32("rst.load", load_data_o, 32'd0);
      chk1("rst.err", bus_err_o, 1'b0);
      chk32("rst.addr", bus_req_addr, 32'd0);
      reset = 1'b1;

      access("lw100", 1'b1, 1'b0, 32'h100, 32'd0, 3'b010, 0, 0, 32'hDEAD_BEEF, 1'b0);
      access("lb103", 1'b1, 1'b0, 32'h103, 32'd0, 3'b000, 0, 1, 32'h80FF_0000, 1'b0);
      access("lbu103", 1'b1, 1'b0, 32'h103, 32'd0, 3'b100, 1, 0, 32'h80FF_0000, 1'b0);
      access("lhu102", 1'b1, 1'b0, 32'h102, 32'd0, 3'b101, 0, 0, 32'h80FF_0000, 1'b0);
      access("lh102", 1'b1, 1'b0, 32'h102, 32'd0, 3'b001, 0, 0, 32'h80FF_0000, 1'b0);
      access("sh202", 1'b0, 1'b1, 32'h202, 32'h1234_ABCD, 3'b001, 0, 0, 32'hFFFF_FFFF, 1'b0);
      access("sb201", 1'b1, 1'b1, 32'h201, 32'h0000_0077, 3'b000, 0, 0, 32'h1111_1111, 1'b0);
      access("sw300", 1'b0, 1'b1, 32'h300, 32'hCAFE_F00D, 3'b010, 2, 2, 32'h0, 1'b0);
      misaligned("lw101", 1'b1, 1'b0, 32'h101, 3'b010);
      misaligned("sh203", 1'b0, 1'b1, 32'h203, 3'b001);
      access("err_wait", 1'b1, 1'b0, 32'h340, 32'd0, 3'b010, 5, 0, 32'h1357_9BDF, 1'b1);

      // Asynchronous reset in the middle of a response wait.
      @(negedge clk);
      drive_op(1'b1, 1'b0, 32'h400, 32'd0, 3'b010);
      @(negedge clk);
      bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0;
      chk1("rstmid.in_resp", stall_o, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk1("rstmid.stall", stall_o, 1'b0);
      chk1("rstmid.valid", bus_req_valid, 1'b0);
      chk1("rstmid.done", done_o, 1'b0);
      chk1("rstmid.mis", misaligned_o, 1'b0);
      chk32("rstmid.addr", bus_req_addr, 32'd0);
      @(negedge clk);
      drive_op(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      @(negedge clk);
      reset = 1'b1;
      access("lw_after_rst", 1'b1, 1'b0, 32'h104, 32'd0, 3'b010, 0, 0, 32'h0BAD_F00D, 1'b0);

`ifdef LSU_TIMEOUT_EN
      @(negedge clk);
      drive_op(1'b1, 1'b0, 32'h500, 32'd0, 3'b010);
      @(negedge clk);
      for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
         chk1("to.valid", bus_req_valid, 1'b1);
         @(negedge clk);
      end
      drive_op(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      chk1("to.done", done_o, 1'b1);
      chk1("to.err", bus_err_o, 1'b1);
      chk32("to.load", load_data_o, 32'd0);
      chk1("to.valid_drop", bus_req_valid, 1'b0);
      bus_rsp_valid = 1'b1;
      @(negedge clk);
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      chk1("to.stray", done_o, 1'b0);
`endif

      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         case ($urandom_range(0, wr ? 2 : 4))
            0:       sz = 3'b000;
            1:       sz = 3'b001;
            2:       sz = 3'b010;
            3:       sz = 3'b100;
            default: sz = 3'b101;
         endcase
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 3'b010) a[1:0] = 2'b00;
            else if (sz == 3'b001 || sz == 3'b101) a[0] = 1'b0;
         end
         if (m_mis(sz, a))
            misaligned("rnd_mis", rd, wr, a, sz);
         else
            access("rnd", rd, wr, a, $urandom, sz, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
